// File: rtl/mult_arb.sv
// Shift-add W x W unsigned multiplier shared by two requesters through a
// round-robin arbiter; one partial product is accumulated per clock.
module mult_arb #(
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [2*W-1:0] c,
    output logic           busy
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           pri;
    logic           sel;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] b_ext;
    logic [CW-1:0]  count;
    logic           accept;
    logic           pick1;
    logic           last_step;

    always_comb begin
        b_ext = {{W{1'b0}}, b_reg};
    end

    // pick1 selects requester 1: it wins when alone, or when both ask and pri favours it
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pick1      = 1'b0;
        acc_next   = acc;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    pick1      = req1 && (!req0 || pri);
                    state_next = RUN;
                end
            end
            RUN: begin
                if (a_reg[count]) begin
                    acc_next = acc + (b_ext << count);
                end
                last_step = (count == LAST);
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            gnt0  <= accept && !pick1;
            gnt1  <= accept && pick1;
            done0 <= last_step && !sel;
            done1 <= last_step && sel;
        end
    end

    // Datapath: operands are captured only on acceptance, so later input changes cannot disturb a running product
    always_ff @(posedge clk) begin
        if (rst) begin
            pri   <= 1'b0;
            sel   <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
            c     <= '0;
        end else if (accept) begin
            sel   <= pick1;
            pri   <= !pick1;
            a_reg <= pick1 ? a1 : a0;
            b_reg <= pick1 ? b1 : b0;
            acc   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (last_step) begin
                c <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_mult_arb.sv
// Self-checking bench for mult_arb: randomized operands and request patterns
// compared against a product/round-robin model kept in the bench.
module tb_mult_arb;

    localparam int W = 6;

    logic           clk;
    logic           rst;
    logic           req0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic           req1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           done0;
    logic           done1;
    logic [2*W-1:0] c;
    logic           busy;

    int checks;
    int errors;
    int last_served;

    mult_arb #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .c     (c),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Round-robin model: a lone requester always wins, otherwise the one not served last
    function automatic int model_winner(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        last_served = 1;
    endtask

    // Stimulus/observation only: waits for a grant, records what was captured, then waits for done
    task automatic run_op(input bit keep, output int gid, output logic [2*W-1:0] expect_c,
                          output int lat, output int did, output logic [2*W-1:0] cv,
                          output int idle, output bit glitch);
        logic [2*W-1:0] c_start;
        gid = -1; lat = -1; did = -1; cv = '0; idle = 0; glitch = 1'b0; expect_c = '0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (gnt0 || gnt1) begin
                gid = (gnt0 && gnt1) ? 2 : (gnt0 ? 0 : 1);
                break;
            end
            if (!busy) idle++;
        end
        if (gid < 0) return;
        if (!busy) glitch = 1'b1;
        expect_c = (gid == 1) ? model_product(a1, b1) : model_product(a0, b0);
        c_start = c;
        if (gid == 0) begin
            a0 = rnd_op(); b0 = rnd_op();
            if (!keep) req0 = 1'b0;
        end else begin
            a1 = rnd_op(); b1 = rnd_op();
            if (!keep) req1 = 1'b0;
        end
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (done0 || done1) begin
                lat = i;
                did = (done0 && done1) ? 2 : (done0 ? 0 : 1);
                cv  = c;
                break;
            end
            if (gnt0 || gnt1 || !busy || c !== c_start) glitch = 1'b1;
        end
    endtask

    task automatic test_reset();
        int gid, lat, did, idle;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        req0 = 1'b1; req1 = 1'b1;
        a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || c !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b c=%0d, expected all 0",
                         gnt0, gnt1, done0, done1, busy, c);
            end
        end
        rst = 1'b0;
        last_served = 1;
        run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
        checks++;
        if (gid !== 0 || idle !== 0) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got grant %0d after %0d idle cycles, expected 0 after 0", gid, idle);
        end
        last_served = 0;
        checks++;
        if (did !== 0 || cv !== ex || lat !== W) begin
            errors++;
            $display("[TB] FAIL reset_first_op: got done %0d c=%0d lat=%0d, expected done 0 c=%0d lat=%0d",
                     did, cv, lat, ex, W);
        end
        req1 = 1'b0;
    endtask

    task automatic test_single();
        int gid, lat, did, idle;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        req0 = 1'b1; a0 = 6'd5; b0 = 6'd7;
        run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
        last_served = 0;
        checks++;
        if (gid !== 0 || did !== 0 || cv !== 12'd35 || lat !== W || glitch) begin
            errors++;
            $display("[TB] FAIL single_5x7: got gnt %0d done %0d c=%0d lat=%0d glitch=%0b, expected 0 0 35 %0d 0",
                     gid, did, cv, lat, glitch, W);
        end
        cycle();
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || c !== 12'd35 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_after_done: got done=%b%b c=%0d busy=%b, expected done=00 c=35 busy=0",
                     done0, done1, c, busy);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] ca [3];
        logic [W-1:0] cb [3];
        int gid, lat, did, idle;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        ca[0] = 6'd63; cb[0] = 6'd63;
        ca[1] = 6'd0;  cb[1] = 6'd63;
        ca[2] = 6'd1;  cb[2] = 6'd42;
        for (int k = 0; k < 3; k++) begin
            req0 = 1'b1; a0 = ca[k]; b0 = cb[k];
            run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
            last_served = 0;
            checks++;
            if (gid !== 0 || did !== 0 || cv !== model_product(ca[k], cb[k]) || lat !== W || glitch) begin
                errors++;
                $display("[TB] FAIL corner_%0dx%0d: got gnt %0d done %0d c=%0d lat=%0d, expected 0 0 %0d %0d",
                         ca[k], cb[k], gid, did, cv, lat, model_product(ca[k], cb[k]), W);
            end
        end
    endtask

    task automatic test_contention();
        int gid, lat, did, idle;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        do_reset();
        req0 = 1'b1; a0 = 6'd3;  b0 = 6'd4;
        req1 = 1'b1; a1 = 6'd10; b1 = 6'd11;
        run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
        checks++;
        if (gid !== 0 || did !== 0 || cv !== 12'd12 || lat !== W) begin
            errors++;
            $display("[TB] FAIL contention_first: got gnt %0d done %0d c=%0d lat=%0d, expected 0 0 12 %0d",
                     gid, did, cv, lat, W);
        end
        run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
        checks++;
        if (gid !== 1 || did !== 1 || cv !== 12'd110 || idle !== 1) begin
            errors++;
            $display("[TB] FAIL contention_second: got gnt %0d done %0d c=%0d idle=%0d, expected 1 1 110 1",
                     gid, did, cv, idle);
        end
        last_served = 1;
    endtask

    task automatic test_fairness();
        int gid, lat, did, idle, want;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        int order [4];
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
        order = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            want = model_winner(1'b1, 1'b1);
            run_op(1'b1, gid, ex, lat, did, cv, idle, glitch);
            checks++;
            if (gid !== order[k] || gid !== want || did !== want || cv !== ex || lat !== W || glitch) begin
                errors++;
                $display("[TB] FAIL fairness_op%0d: got gnt %0d done %0d c=%0d lat=%0d glitch=%0b, expected %0d %0d %0d %0d 0",
                         k, gid, did, cv, lat, glitch, order[k], want, ex, W);
            end
            checks++;
            if (idle !== ((k == 0) ? 0 : 1)) begin
                errors++;
                $display("[TB] FAIL fairness_gap%0d: got %0d idle cycles, expected %0d", k, idle, (k == 0) ? 0 : 1);
            end
            last_served = want;
        end
    endtask

    task automatic test_random();
        int gid, lat, did, idle, want, p;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        for (int k = 0; k < 16; k++) begin
            p = int'($urandom_range(1, 3));
            req0 = p[0]; req1 = p[1];
            a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
            want = model_winner(p[0], p[1]);
            ex = (want == 0) ? model_product(a0, b0) : model_product(a1, b1);
            run_op(1'b0, gid, cv, lat, did, cv, idle, glitch);
            run_check: begin
                checks++;
                if (gid !== want || did !== want || cv !== ex || lat !== W || glitch || (k > 0 && idle !== 1)) begin
                    errors++;
                    $display("[TB] FAIL random_op%0d: got gnt %0d done %0d c=%0d lat=%0d idle=%0d glitch=%0b, expected %0d %0d %0d %0d 1 0",
                             k, gid, did, cv, lat, idle, glitch, want, want, ex, W);
                end
            end
            last_served = want;
        end
    endtask

    task automatic test_reset_mid_op();
        int gid, lat, did, idle, seen, late;
        bit glitch;
        logic [2*W-1:0] cv, ex;
        req0 = 1'b0; req1 = 1'b1;
        a1 = 6'd50; b1 = 6'd33;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (gnt1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("[TB] FAIL midreset_grant: got no gnt1 within 30 cycles, expected one");
        end
        req1 = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (done1 !== 1'b0 || c !== '0 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got done1=%b c=%0d busy=%b gnt=%b%b, expected 0 0 0 00",
                     done1, c, busy, gnt0, gnt1);
        end
        rst = 1'b0;
        last_served = 1;
        late = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (done0 || done1 || busy || c !== '0) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got %0d active cycles after reset, expected 0", late);
        end
        req0 = 1'b1; req1 = 1'b1;
        a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
        run_op(1'b0, gid, ex, lat, did, cv, idle, glitch);
        checks++;
        if (gid !== 0 || did !== 0 || cv !== ex) begin
            errors++;
            $display("[TB] FAIL midreset_next: got gnt %0d done %0d c=%0d, expected 0 0 %0d", gid, did, cv, ex);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_served = 1;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_corners();
        test_contention();
        test_fairness();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
